seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 50000, clock cycles per digit slot (legal range 1..2^20).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ones  input  4  BCD digit, leftmost position (an[3]).
REQ-005 SHALL have port tenths  input  4  BCD digit, position an[2].
REQ-006 SHALL have port hundreths  input  4  BCD digit, position an[1].
REQ-007 SHALL have port thousandths  input  4  BCD digit, rightmost position (an[0]).
REQ-008 SHALL have port blank  input  1  active-high, all digits dark.
REQ-009 SHALL have port lamp_test  input  1  active-high, all segments, decimal points and anodes lit.
REQ-010 SHALL have port an  output  4  active-low digit anodes, registered.
REQ-011 SHALL have port seg  output  7  active-low cathodes, bit order {g,f,e,d,c,b,a}, registered.
REQ-012 SHALL have port dp  output  1  active-low decimal point, registered.

Function
REQ-013 SHALL run a prescaler counting 0..REFRESH_DIV-1 and wrapping to 0; tick SHALL be high in the cycle the count equals REFRESH_DIV-1.
REQ-014 SHALL run a 2-bit digit index idx that increments on tick, wrapping 3->0.
REQ-015 SHALL hold a 16-bit snapshot of {ones,tenths,hundreths,thousandths}, loaded only on tick with idx==3, so that one full scan shows one coherent value.
REQ-016 Input digits SHALL NOT affect outputs except through the snapshot.
REQ-017 SHALL select snapshot nibble idx (0=thousandths .. 3=ones) and register outputs every cycle; outputs SHALL lag idx/snapshot by exactly one cycle.
REQ-018 In normal mode, an SHALL have exactly bit idx low and all other bits high.
REQ-019 seg SHALL encode values 0..9 as 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, respectively.
REQ-020 Non-BCD values 10..15 SHALL display a dash, seg = 0111111.
REQ-021 dp SHALL be low only when idx==3, giving format D.DDD.
REQ-022 blank SHALL force an=1111, seg=1111111, dp=1 on the next edge.
REQ-023 lamp_test SHALL force an=0000, seg=0000000, dp=0 on the next edge.
REQ-024 blank SHALL take priority over lamp_test.
REQ-025 Prescaler, idx and snapshot SHALL keep running while blank or lamp_test is asserted; on release, normal output SHALL resume next edge at the current idx.
REQ-026 With REFRESH_DIV=1, tick SHALL be high every cycle and idx SHALL advance every cycle.
REQ-027 Prescaler width SHALL be clog2(REFRESH_DIV), minimum 1 bit, with no overflow beyond REFRESH_DIV-1.

Reset
REQ-028 While rst is high, prescaler=0, idx=0, snapshot=0, an=1111, seg=1111111, dp=1, independent of clk.
REQ-029 First edge after rst deasserts SHALL give an=1110, seg=1000000 (snapshot 0), dp=1.
REQ-030 rst asserted mid-scan SHALL take effect immediately and restart scanning at idx=0 with no partial slot carried over.

Verification (REFRESH_DIV=4)
REQ-031 Inputs 1,2,3,4 held; release reset; run 40 cycles -> after first full scan, an cycles 1110/1101/1011/0111 at 4 cycles each, seg 0110000/0100100/1111001 (digit 4 = 0011001) in step, dp=0 only with an=0111.
REQ-032 Change inputs 1,2,3,4 -> 5,6,7,8 mid-scan at idx=1 -> old digits on idx 2,3; new digits only from next idx=0 slot.
REQ-033 thousandths=4'hC -> seg=0111111 during an=1110 slot; other digits normal.
REQ-034 Assert blank and lamp_test together, then drop blank -> 1111/1111111/1 while both high; then 0000/0000000/0; idx keeps counting throughout.
REQ-035 Assert rst asynchronously between edges during idx=2 -> an=1111 immediately; after release an=1110 and snapshot reloads at end of the first scan.
REQ-036 REFRESH_DIV=1 with inputs 9,9,9,9 -> an rotates every cycle, seg=0010000 constantly after first scan.

Source files
------------

// File: rtl/seg_scan_driver.sv
// Four-digit multiplexed seven-segment driver: scans a coherent BCD snapshot
// across active-low anodes with blank and lamp-test overrides.
module seg_scan_driver #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ones,
  input  logic [3:0] tenths,
  input  logic [3:0] hundreths,
  input  logic [3:0] thousandths,
  input  logic       blank,
  input  logic       lamp_test,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [15:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             tick;
  logic [3:0]       nibble;

  function automatic logic [6:0] seg_encode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  always_comb begin
    tick   = (cnt_q == CNT_MAX);
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? idx_q + 2'd1 : idx_q;
    // Snapshot only refreshes at the end of a full scan so all four slots agree.
    snap_d = (tick && idx_q == 2'd3) ? {ones, tenths, hundreths, thousandths} : snap_q;

    case (idx_q)
      2'd0:    nibble = snap_q[3:0];
      2'd1:    nibble = snap_q[7:4];
      2'd2:    nibble = snap_q[11:8];
      default: nibble = snap_q[15:12];
    endcase

    an_d  = ~(4'b0001 << idx_q);
    seg_d = seg_encode(nibble);
    dp_d  = (idx_q != 2'd3);

    if (blank) begin
      an_d  = '1;
      seg_d = '1;
      dp_d  = 1'b1;
    end else if (lamp_test) begin
      an_d  = '0;
      seg_d = '0;
      dp_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      an_q   <= '1;
      seg_q  <= '1;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
      dp_q   <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule
